// File: rtl/upload_pkg.sv
// Shared constants for the USB upload path: source lane indices, source IDs and
// the arbiter state encoding.
// Combinational definitions only; no latency or backpressure of its own.
// Ports: none (package).
package upload_pkg;

  localparam int SRC_IDX_UART = 0;
  localparam int SRC_IDX_I2C  = 1;

  localparam logic [7:0] SRC_ID_UART = 8'h01;
  localparam logic [7:0] SRC_ID_I2C  = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } upload_state_t;

endpackage

// File: rtl/upload_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
// Ports:
//   req    in  NUM_SRC  request vector
//   last   in  IDX_W    index of the most recent winner (lowest priority now)
//   winner out IDX_W    selected index (0 when nothing requests)
//   found  out 1        at least one request bit is set
module rr_pick
  import upload_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  int cand;

  // Walk candidates from the farthest (last itself) to the nearest (last+1) so
  // the nearest requester overwrites any farther one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = int'(last) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if ((i == cand) && req[i]) begin
          winner = IDX_W'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/upload_arbiter.sv
// Packet-granular round-robin arbiter sharing the USB upload port among N handlers.
// Latency: 1 cycle request-to-grant, then a zero-latency combinational lane mux.
// Backpressure: up_ready passes straight to the owner's src_ready; others wait with ready low.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   src_req/src_valid/src_ready      per-source handshake (NUM_SRC bits each)
//   src_data/src_source              per-source byte and source ID, lane i at [8i+7:8i]
//   up_req/up_data/up_source         to command_processor upload_*_in
//   up_valid/up_ready                beat handshake with command_processor
//   grant_idx, busy                  current owner index and port-owned flag
//   timeout_pulse                    one-cycle strobe when an idle owner is forced off
module upload_arbiter
  import upload_pkg::*;
#(
  parameter  int NUM_SRC     = 2,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int IDX_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [8*NUM_SRC-1:0] src_source,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 up_req,
  output logic [7:0]           up_data,
  output logic [7:0]           up_source,
  output logic                 up_valid,
  input  logic                 up_ready,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [IDX_W-1:0] RR_RST   = IDX_W'(NUM_SRC - 1);

  upload_state_t    state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_nxt;
  logic             busy_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  logic             lane_req;
  logic             lane_valid;
  logic [7:0]       lane_data;
  logic [7:0]       lane_source;
  logic             xfer;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req    (src_req),
    .last   (rr_ptr),
    .winner (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= RR_RST;
      grant_idx <= '0;
      busy      <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_nxt;
      busy      <= busy_nxt;
      timer     <= timer_nxt;
    end
  end

  // Granted-lane select, independent of state; only used while granted.
  always_comb begin
    lane_req    = 1'b0;
    lane_valid  = 1'b0;
    lane_data   = '0;
    lane_source = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i == int'(grant_idx)) begin
        lane_req    = src_req[i];
        lane_valid  = src_valid[i];
        lane_data   = src_data[8*i +: 8];
        lane_source = src_source[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_idx;
    busy_nxt      = busy;
    timer_nxt     = timer;
    up_req        = 1'b0;
    up_data       = '0;
    up_source     = '0;
    up_valid      = 1'b0;
    src_ready     = '0;
    timeout_pulse = 1'b0;
    xfer          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt  = pick_idx;
          rr_ptr_nxt = pick_idx;
          busy_nxt   = 1'b1;
          timer_nxt  = '0;
          state_nxt  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        up_req    = lane_req;
        up_data   = lane_data;
        up_source = lane_source;
        // A trailing valid after req has dropped belongs to no packet.
        up_valid  = lane_valid & lane_req;
        for (int i = 0; i < NUM_SRC; i++) begin
          src_ready[i] = (i == int'(grant_idx)) & up_ready;
        end
        xfer = up_valid & up_ready;

        if (!lane_req) begin
          state_nxt = ST_RELEASE;
        end else if (xfer) begin
          timer_nxt = '0;
        end else if (timer == TMR_LAST) begin
          timeout_pulse = 1'b1;
          state_nxt     = ST_RELEASE;
        end else if (timer != TMR_MAX) begin
          timer_nxt = timer + TMR_W'(1);
        end
      end

      ST_RELEASE: begin
        // One dead cycle so command_processor always sees up_req low between packets.
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_upload_arbiter.sv
// Randomised bench for upload_arbiter with a transaction-level port model and byte scoreboard.
module tb_upload_arbiter;
  import upload_pkg::*;

  localparam int N  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   src_req = '0;
  logic [8*N-1:0] src_data = '0;
  logic [8*N-1:0] src_source = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_ready;
  logic           up_req;
  logic [7:0]     up_data;
  logic [7:0]     up_source;
  logic           up_valid;
  logic           up_ready = 1'b0;
  logic [0:0]     grant_idx;
  logic           busy;
  logic           timeout_pulse;

  always #5 clk = ~clk;

  upload_arbiter #(.NUM_SRC(N), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_req       (src_req),
    .src_data      (src_data),
    .src_source    (src_source),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .up_req        (up_req),
    .up_data       (up_data),
    .up_source     (up_source),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  int vectors = 0;
  int errors  = 0;

  // Source behaviour: each source holds one packet at a time in txq.
  logic [7:0] txq  [N][$];
  logic [7:0] expq [N][$];
  logic [7:0] rxq  [N][$];
  bit         want [N];
  bit         stall[N];
  int         pkts_left[N];
  int         plen  = 0;   // 0: random packet length 1..4
  int         vmode = 0;   // 0: valid whenever data available, 1: random gaps
  int         rmode = 0;   // 0: ready high, 1: toggle, 2: random

  // Port model: who owns the port, whether this is the post-packet gap cycle,
  // last winner and silent cycles of the current owner.
  int own, last, quiet;
  bit gap;

  int obs_grants[$];
  bit prev_busy = 1'b0;
  int busy_age  = 0;
  int n_pulse   = 0;

  function automatic logic [7:0] src_id(input int i);
    return (i == SRC_IDX_UART) ? SRC_ID_UART : SRC_ID_I2C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pkt(input int i, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      txq[i].push_back(b);
      expq[i].push_back(b);
    end
    want[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_req[i]   = want[i];
      src_valid[i] = want[i] && !stall[i] && (txq[i].size() > 0) &&
                     (vmode == 0 || $urandom_range(0, 3) != 0);
      src_data[8*i +: 8]   = (txq[i].size() > 0) ? txq[i][0] : 8'($urandom);
      src_source[8*i +: 8] = src_id(i);
    end
    case (rmode)
      0:       up_ready = 1'b1;
      1:       up_ready = ~up_ready;
      default: up_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic update_drivers();
    for (int i = 0; i < N; i++) begin
      if (want[i] && txq[i].size() == 0) begin
        want[i] = 1'b0;
      end else if (!want[i] && pkts_left[i] > 0) begin
        load_pkt(i, (plen == 0) ? $urandom_range(1, 4) : plen);
        pkts_left[i]--;
      end
    end
  endtask

  task automatic check_cycle();
    bit ob, rq, vl, xf, to_exp;
    logic [N-1:0] er;
    logic [7:0] junk;
    ob     = (own >= 0);
    rq     = ob ? src_req[own] : 1'b0;
    vl     = ob ? (src_req[own] & src_valid[own]) : 1'b0;
    xf     = vl & up_ready;
    to_exp = ob && rq && !xf && (quiet == TO - 1);
    er = '0;
    if (ob) er[own] = up_ready;

    chk("busy", busy, ob || gap);
    chk("up_req", up_req, rq);
    chk("up_valid", up_valid, vl);
    chk("src_ready", src_ready, er);
    chk("timeout_pulse", timeout_pulse, to_exp);
    if (ob || gap) chk("grant_idx", grant_idx, last);
    if (vl) begin
      chk("up_data", up_data, txq[own][0]);
      chk("up_source", up_source, src_id(own));
    end

    if (busy && !prev_busy) obs_grants.push_back(int'(grant_idx));
    busy_age  = busy ? (prev_busy ? busy_age + 1 : 1) : 0;
    prev_busy = busy;
    if (timeout_pulse) begin
      n_pulse++;
      chk("timeout_cycle", busy_age, TO);
    end

    if (xf) begin
      rxq[own].push_back(up_data);
      junk = txq[own].pop_front();
    end

    if (ob) begin
      if (!rq) begin
        own = -1; gap = 1'b1;
      end else if (xf) begin
        quiet = 0;
      end else if (quiet == TO - 1) begin
        own = -1; gap = 1'b1;
      end else begin
        quiet++;
      end
    end else if (gap) begin
      gap = 1'b0;
    end else if (src_req != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (src_req[(last + k) % N]) begin
          own = (last + k) % N;
          break;
        end
      end
      last  = own;
      quiet = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    update_drivers();
    drive();
  endtask

  function automatic bit all_idle();
    bit r;
    r = (own < 0) && !gap;
    for (int i = 0; i < N; i++) begin
      if (want[i] || txq[i].size() != 0 || pkts_left[i] != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic check_bytes();
    for (int i = 0; i < N; i++) begin
      chk("rx_len", rxq[i].size(), expq[i].size());
      for (int k = 0; k < expq[i].size() && k < rxq[i].size(); k++) begin
        chk("rx_byte", rxq[i][k], expq[i][k]);
      end
      rxq[i].delete();
      expq[i].delete();
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while (!all_idle() && n < limit) begin
      step();
      n++;
    end
    if (!all_idle()) begin
      vectors++;
      errors++;
      $error("FAIL wait_bound observed=%0d cycles expected=idle within %0d", n, limit);
    end
    check_bytes();
  endtask

  task automatic check_grants(input int n, input int g0, input int g1, input int g2, input int g3);
    int e[4];
    e[0] = g0; e[1] = g1; e[2] = g2; e[3] = g3;
    chk("grant_count", obs_grants.size(), n);
    for (int k = 0; k < n && k < obs_grants.size(); k++) begin
      chk("grant_order", obs_grants[k], e[k]);
    end
    obs_grants.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_up_req", up_req, 1'b0);
    chk("rst_up_valid", up_valid, 1'b0);
    chk("rst_src_ready", src_ready, '0);
    chk("rst_grant_idx", grant_idx, '0);
    chk("rst_timeout", timeout_pulse, 1'b0);
    chk("rst_up_data", up_data, '0);
    for (int i = 0; i < N; i++) begin
      want[i] = 1'b0; stall[i] = 1'b0; pkts_left[i] = 0;
      txq[i].delete(); rxq[i].delete(); expq[i].delete();
    end
    rmode = 0; vmode = 0; plen = 0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    own = -1; gap = 1'b0; last = N - 1; quiet = 0;
    obs_grants.delete();
    prev_busy = 1'b0; busy_age = 0;
    drive();
  endtask

  initial begin
    #2;
    do_reset();

    // Single source, fixed bytes, ready always high.
    txq[0] = '{8'h11, 8'h22, 8'h33};
    expq[0] = '{8'h11, 8'h22, 8'h33};
    want[0] = 1'b1;
    drive();
    run_until_idle(50);
    check_grants(1, 0, 0, 0, 0);

    // Simultaneous requests after reset: lane 0 first, lane 1 bytes held back.
    do_reset();
    load_pkt(0, 3);
    txq[1] = '{8'hAA, 8'hBB};
    expq[1] = '{8'hAA, 8'hBB};
    want[1] = 1'b1;
    drive();
    run_until_idle(60);
    check_grants(2, 0, 1, 0, 0);

    // Toggling ready with random valid gaps.
    rmode = 1; vmode = 1;
    pkts_left[0] = 3; pkts_left[1] = 3;
    update_drivers();
    drive();
    run_until_idle(400);
    obs_grants.delete();

    // Stalled owner is forced off after TO silent cycles, then returns later.
    do_reset();
    n_pulse = 0;
    stall[0] = 1'b1;
    load_pkt(0, 3);
    load_pkt(1, 2);
    drive();
    for (int c = 0; c < 30; c++) step();
    stall[0] = 1'b0;
    run_until_idle(100);
    chk("timeout_count", n_pulse, 1);
    check_grants(3, 0, 1, 0, 0);

    // Both sources keep requesting 2-byte packets: grants alternate.
    do_reset();
    plen = 2;
    pkts_left[0] = 2; pkts_left[1] = 2;
    update_drivers();
    drive();
    run_until_idle(100);
    check_grants(4, 0, 1, 0, 1);

    // Random ready and valid, longer run.
    rmode = 2; vmode = 1; plen = 0;
    pkts_left[0] = 5; pkts_left[1] = 5;
    update_drivers();
    drive();
    run_until_idle(800);
    obs_grants.delete();

    // Reset while byte 2 of a packet is on the port.
    do_reset();
    load_pkt(0, 4);
    load_pkt(1, 2);
    drive();
    for (int c = 0; c < 20 && rxq[0].size() < 1; c++) step();
    chk("pre_reset_bytes", rxq[0].size(), 1);
    do_reset();
    load_pkt(0, 2);
    load_pkt(1, 2);
    drive();
    run_until_idle(60);
    check_grants(2, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
